multi_data_sync: RTL and testbench
==================================

# multi_data_sync

Multi-channel, parametrised bus synchroniser for the destination clock domain of the processing system. Each channel receives a quasi-static bus qualified by an enable signal from a foreign domain, synchronises the enable through a configurable flop chain, and captures the bus on the detected event. Captured words are presented downstream through a per-channel valid/ready handshake with overrun detection. An optional acknowledge toggle returns to the source domain.

## Interface
- NUM_STAGES, 2 — synchroniser depth per channel; legal range 2..4.
- BUS_WIDTH, 8 — data bits per channel.
- NUM_CH, 2 — number of independent channels; legal range 1..8.
- TOGGLE_MODE, 0 — 0: enable is a level, event on rising edge; 1: enable is a toggle, event on any edge.

- clk  in  1  destination clock.
- rst  in  1  reset, asynchronous, active-low.
- bus_enable  in  NUM_CH  unsynchronised enable/toggle, one bit per channel.
- unsync_bus  in  NUM_CH*BUS_WIDTH  source data; channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH].
- sync_bus  out  NUM_CH*BUS_WIDTH  captured data, same packing.
- enable_pulse  out  NUM_CH  one-cycle strobe per capture.
- sync_valid  out  NUM_CH  captured word awaiting consumption.
- sync_ready  in  NUM_CH  downstream accepts the word.
- overrun  out  NUM_CH  sticky: an event was dropped.
- overrun_clr  in  NUM_CH  clears overrun.
- ack_toggle  out  NUM_CH  flips once per consumed word.

## Operation
- Per-channel state: IDLE (sync_valid=0) and HOLD (sync_valid=1).
- Sync chain: bus_enable[c] shifted through NUM_STAGES flops. A further flop holds the previous chain output.
- Event: rising edge of chain output (TOGGLE_MODE=0) or any change (TOGGLE_MODE=1), decoded combinationally from the last two flops.
- IDLE + event: capture unsync_bus[c] into sync_bus[c], assert enable_pulse[c] for one cycle, go to HOLD.
- HOLD + sync_ready: transfer; go to IDLE. If an event occurs in the same cycle, capture it and stay in HOLD with no overrun.
- HOLD + event + !sync_ready: keep old data, set overrun[c], no enable_pulse.
- overrun_clr clears overrun[c]. If a set and a clear occur in the same cycle, the set wins.
- sync_bus holds its value at all times other than a capture.
- Channels are fully independent; there is no arbitration between them.
- Reset values (any time, including mid-transfer): every chain flop 0, sync_bus 0, enable_pulse 0, sync_valid 0, overrun 0, ack_toggle 0. The state after reset is IDLE. A level-high bus_enable still present after reset release produces one event (mode 0).

## Timing
- Latency: bus_enable change sampled at edge k; sync_bus, enable_pulse and sync_valid are valid after edge k+NUM_STAGES.
- enable_pulse is exactly one cycle wide, coincident with the first cycle of new sync_bus data.
- Handshake: transfer occurs at the edge where sync_valid&sync_ready=1. sync_valid falls after that edge unless a simultaneous capture occurs.
- Source contract: unsync_bus is stable from NUM_STAGES+1 cycles before the enable event until the event is captured.
- Back-to-back events: rate of at most one per 2 destination cycles in mode 1. Faster events are merged by the chain; this is not detected.

## Configuration
- MULTI_DATA_SYNC_ACK_EN defined: ack_toggle[c] inverts at the edge a transfer completes on channel c.
- MULTI_DATA_SYNC_ACK_EN undefined: ack_toggle is tied to 0, no ack flops are built, and the port remains present.

## Structure
- Package multi_data_sync_pkg:
  - MIN_STAGES=2 and MAX_STAGES=4 constants.
  - Mode encoding constants MODE_LEVEL=0 and MODE_TOGGLE=1.
  - Channel state typedef {IDLE, HOLD}.
- Sub-module sync_chan: one channel (chain, edge detect, capture, handshake, overrun, ack).
- The top instantiates NUM_CH copies in a generate loop and performs parameter range checks.

## Test plan
- Reset mid-HOLD: rst low while sync_valid=1 with data 0xA5 -> all outputs 0 immediately; no event after release while bus_enable=0.
- Mode 0, NUM_STAGES=2: bus_enable rises at edge 10 with bus 0x3C -> sync_bus=0x3C, enable_pulse high only in the cycle after edge 12, sync_valid high; ready at edge 15 -> sync_valid low after edge 15.
- Overrun: HOLD with 0x11, ready=0, second event with 0x22 -> sync_bus stays 0x11, overrun=1, no pulse. overrun_clr and a new event in the same cycle -> overrun stays 1.
- Simultaneous ready and event: HOLD with 0x01, ready=1 as event with 0x02 is detected -> sync_bus=0x02, sync_valid stays 1, overrun=0.
- Mode 1, NUM_STAGES=3, NUM_CH=3: toggle ch1 twice 4 cycles apart with 0x55, 0xAA, consuming each -> two pulses 3 cycles after each toggle; ch0/ch2 remain idle.
- With MULTI_DATA_SYNC_ACK_EN: three consumed words -> ack_toggle ends at 1. Without the macro -> ack_toggle constant 0.

Source files
------------

// File: rtl/multi_data_sync_pkg.sv
// multi_data_sync_pkg
//   Shared constants and types for the multi-channel bus synchroniser.
//   MIN_STAGES/MAX_STAGES bound the synchroniser depth, MODE_* encode the
//   TOGGLE_MODE parameter, chan_state_t is the per-channel handshake state.
package multi_data_sync_pkg;

  localparam int unsigned MIN_STAGES  = 2;
  localparam int unsigned MAX_STAGES  = 4;

  localparam int unsigned MODE_LEVEL  = 0;
  localparam int unsigned MODE_TOGGLE = 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } chan_state_t;

endpackage

// File: rtl/multi_data_sync_sync_chan.sv
// sync_chan
//   One synchroniser channel: enable/toggle sync chain, event decode,
//   bus capture, valid/ready handshake, sticky overrun and optional ack.
//   Optional feature macro: MULTI_DATA_SYNC_ACK_EN (builds the ack toggle flop).
// Ports:
//   clk, rst          destination clock, async active-low reset
//   bus_enable        unsynchronised enable (level) or toggle
//   unsync_bus        source data, quasi-static around the event
//   sync_bus          captured data
//   enable_pulse      one-cycle strobe on capture
//   sync_valid        captured word awaiting consumption
//   sync_ready        downstream accepts the word
//   overrun           sticky: an event was dropped
//   overrun_clr       clears overrun (a simultaneous set wins)
//   ack_toggle        flips once per consumed word (0 without the macro)
module sync_chan
  import multi_data_sync_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 2,
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned TOGGLE_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bus_enable,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse,
  output logic                 sync_valid,
  input  logic                 sync_ready,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 ack_toggle
);

  logic [NUM_STAGES-1:0] sync_ff;
  logic                  prev_ff;
  logic                  evt;
  chan_state_t           state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_ff <= '0;
      prev_ff <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[NUM_STAGES-2:0], bus_enable};
      prev_ff <= sync_ff[NUM_STAGES-1];
    end
  end

  always_comb begin
    evt = 1'b0;
    if (TOGGLE_MODE == MODE_TOGGLE)
      evt = sync_ff[NUM_STAGES-1] ^ prev_ff;
    else
      evt = sync_ff[NUM_STAGES-1] & ~prev_ff;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      sync_bus     <= '0;
      enable_pulse <= 1'b0;
      sync_valid   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      enable_pulse <= 1'b0;
      // Clear first so a set later in this block takes priority.
      if (overrun_clr)
        overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (evt) begin
            sync_bus     <= unsync_bus;
            enable_pulse <= 1'b1;
            sync_valid   <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (sync_ready) begin
            if (evt) begin
              sync_bus     <= unsync_bus;
              enable_pulse <= 1'b1;
            end else begin
              sync_valid <= 1'b0;
              state      <= IDLE;
            end
          end else if (evt) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          sync_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef MULTI_DATA_SYNC_ACK_EN
  logic ack_q;
  logic xfer;

  assign xfer = sync_valid & sync_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ack_q <= 1'b0;
    else if (xfer)
      ack_q <= ~ack_q;
  end

  assign ack_toggle = ack_q;
`else
  assign ack_toggle = 1'b0;
`endif

endmodule

// File: rtl/multi_data_sync.sv
// multi_data_sync
//   Multi-channel parametrised bus synchroniser into the clk domain.
//   NUM_CH independent sync_chan instances; no arbitration between them.
//   Optional feature macro: MULTI_DATA_SYNC_ACK_EN (per-channel ack toggle).
// Parameters: NUM_STAGES (2..4), BUS_WIDTH, NUM_CH (1..8), TOGGLE_MODE (0 level, 1 toggle)
// Ports (channel c at [c*BUS_WIDTH +: BUS_WIDTH] / bit c):
//   clk, rst (async, active-low), bus_enable, unsync_bus, sync_bus,
//   enable_pulse, sync_valid, sync_ready, overrun, overrun_clr, ack_toggle
module multi_data_sync
  import multi_data_sync_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 2,
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned TOGGLE_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH-1:0]           sync_valid,
  input  logic [NUM_CH-1:0]           sync_ready,
  output logic [NUM_CH-1:0]           overrun,
  input  logic [NUM_CH-1:0]           overrun_clr,
  output logic [NUM_CH-1:0]           ack_toggle
);

  if (NUM_STAGES < MIN_STAGES || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
    $error("multi_data_sync: NUM_STAGES out of range 2..4");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
    $error("multi_data_sync: NUM_CH out of range 1..8");
  end
  if (TOGGLE_MODE != MODE_LEVEL && TOGGLE_MODE != MODE_TOGGLE) begin : g_bad_mode
    $error("multi_data_sync: TOGGLE_MODE must be 0 or 1");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sync_chan #(
      .NUM_STAGES (NUM_STAGES),
      .BUS_WIDTH  (BUS_WIDTH),
      .TOGGLE_MODE(TOGGLE_MODE)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .bus_enable  (bus_enable[c]),
      .unsync_bus  (unsync_bus[c*BUS_WIDTH +: BUS_WIDTH]),
      .sync_bus    (sync_bus[c*BUS_WIDTH +: BUS_WIDTH]),
      .enable_pulse(enable_pulse[c]),
      .sync_valid  (sync_valid[c]),
      .sync_ready  (sync_ready[c]),
      .overrun     (overrun[c]),
      .overrun_clr (overrun_clr[c]),
      .ack_toggle  (ack_toggle[c])
    );
  end

endmodule

// File: tb/tb_multi_data_sync.sv
// tb_multi_data_sync
//   Self-checking bench: dut0 (level mode, 2 stages, 2 channels) driven from a
//   per-cycle vector table on channel 0, then a reset-in-HOLD sequence;
//   dut1 (toggle mode, 3 stages, 3 channels) driven by a hand sequence on ch1.
module tb_multi_data_sync;

`ifdef MULTI_DATA_SYNC_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // dut0: NUM_STAGES=2, mode 0, 2 channels
  logic [1:0]  en0, rdy0, clr0, pulse0, valid0, ovr0, ack0;
  logic [15:0] bus0, sb0;
  // dut1: NUM_STAGES=3, mode 1, 3 channels
  logic [2:0]  en1, rdy1, clr1, pulse1, valid1, ovr1, ack1;
  logic [23:0] bus1, sb1;

  multi_data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8), .NUM_CH(2), .TOGGLE_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .bus_enable(en0), .unsync_bus(bus0), .sync_bus(sb0),
    .enable_pulse(pulse0), .sync_valid(valid0), .sync_ready(rdy0), .overrun(ovr0),
    .overrun_clr(clr0), .ack_toggle(ack0)
  );

  multi_data_sync #(.NUM_STAGES(3), .BUS_WIDTH(8), .NUM_CH(3), .TOGGLE_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .bus_enable(en1), .unsync_bus(bus1), .sync_bus(sb1),
    .enable_pulse(pulse1), .sync_valid(valid1), .sync_ready(rdy1), .overrun(ovr1),
    .overrun_clr(clr1), .ack_toggle(ack1)
  );

  typedef struct {
    logic       en;
    logic [7:0] bus;
    logic       rdy;
    logic       clr;
    logic [7:0] sb;
    logic       pulse;
    logic       valid;
    logic       ovr;
    logic       ack;   // parity of transfers so far; masked when ack is not built
  } vec_t;

  vec_t vecs[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  function automatic void add(logic en, logic [7:0] bus, logic rdy, logic clr,
                              logic [7:0] sb, logic pulse, logic valid, logic ovr, logic ack);
    vec_t v;
    v.en = en; v.bus = bus; v.rdy = rdy; v.clr = clr;
    v.sb = sb; v.pulse = pulse; v.valid = valid; v.ovr = ovr; v.ack = ack;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    en0 = '0; rdy0 = '0; clr0 = '0; bus0 = '0;
    en1 = '0; rdy1 = '0; clr1 = '0; bus1 = '0;

    //   en bus   rdy clr | sb   pulse valid ovr ack
    add(1, 8'h3C, 0, 0,  8'h00, 0, 0, 0, 0);  // 1  sampled
    add(1, 8'h3C, 0, 0,  8'h00, 0, 0, 0, 0);  // 2  event decoded
    add(1, 8'h3C, 0, 0,  8'h3C, 1, 1, 0, 0);  // 3  capture
    add(1, 8'h3C, 0, 0,  8'h3C, 0, 1, 0, 0);
    add(1, 8'h3C, 1, 0,  8'h3C, 0, 0, 0, 1);  // 5  transfer
    add(0, 8'h3C, 0, 0,  8'h3C, 0, 0, 0, 1);
    add(0, 8'h11, 0, 0,  8'h3C, 0, 0, 0, 1);
    add(0, 8'h11, 0, 0,  8'h3C, 0, 0, 0, 1);
    add(1, 8'h11, 0, 0,  8'h3C, 0, 0, 0, 1);
    add(1, 8'h11, 0, 0,  8'h3C, 0, 0, 0, 1);
    add(1, 8'h11, 0, 0,  8'h11, 1, 1, 0, 1);  // 11 capture 0x11
    add(0, 8'h11, 0, 0,  8'h11, 0, 1, 0, 1);
    add(0, 8'h22, 0, 0,  8'h11, 0, 1, 0, 1);
    add(1, 8'h22, 0, 0,  8'h11, 0, 1, 0, 1);
    add(1, 8'h22, 0, 0,  8'h11, 0, 1, 0, 1);
    add(1, 8'h22, 0, 0,  8'h11, 0, 1, 1, 1);  // 16 dropped event -> overrun
    add(1, 8'h22, 0, 0,  8'h11, 0, 1, 1, 1);
    add(0, 8'h22, 0, 0,  8'h11, 0, 1, 1, 1);
    add(0, 8'h22, 0, 0,  8'h11, 0, 1, 1, 1);
    add(1, 8'h22, 0, 0,  8'h11, 0, 1, 1, 1);
    add(1, 8'h22, 0, 0,  8'h11, 0, 1, 1, 1);
    add(1, 8'h22, 0, 1,  8'h11, 0, 1, 1, 1);  // 22 clear + set -> set wins
    add(1, 8'h22, 0, 1,  8'h11, 0, 1, 0, 1);  // 23 clear alone
    add(1, 8'h22, 1, 0,  8'h11, 0, 0, 0, 0);  // 24 transfer
    add(0, 8'h01, 0, 0,  8'h11, 0, 0, 0, 0);
    add(0, 8'h01, 0, 0,  8'h11, 0, 0, 0, 0);
    add(1, 8'h01, 0, 0,  8'h11, 0, 0, 0, 0);
    add(1, 8'h01, 0, 0,  8'h11, 0, 0, 0, 0);
    add(1, 8'h01, 0, 0,  8'h01, 1, 1, 0, 0);  // 29 capture 0x01
    add(0, 8'h02, 0, 0,  8'h01, 0, 1, 0, 0);
    add(0, 8'h02, 0, 0,  8'h01, 0, 1, 0, 0);
    add(1, 8'h02, 0, 0,  8'h01, 0, 1, 0, 0);
    add(1, 8'h02, 0, 0,  8'h01, 0, 1, 0, 0);
    add(1, 8'h02, 1, 0,  8'h02, 1, 1, 0, 1);  // 34 ready + event together
    add(1, 8'h02, 1, 0,  8'h02, 0, 0, 0, 0);  // 35 transfer

    // Reset state
    repeat (2) step();
    chk("rst_sync_bus0", sb0, 0);
    chk("rst_valid0", valid0, 0);
    chk("rst_pulse0", pulse0, 0);
    chk("rst_ovr0", ovr0, 0);
    chk("rst_sync_bus1", sb1, 0);
    chk("rst_valid1", valid1, 0);
    rst = 1'b1;

    // Table-driven channel 0 of dut0; channel 1 must stay idle
    foreach (vecs[i]) begin
      en0[0] = vecs[i].en; bus0[7:0] = vecs[i].bus;
      rdy0[0] = vecs[i].rdy; clr0[0] = vecs[i].clr;
      bus0[15:8] = 8'h5A;
      step();
      chk($sformatf("v%0d_sync_bus", i), sb0[7:0], vecs[i].sb);
      chk($sformatf("v%0d_pulse", i), pulse0[0], vecs[i].pulse);
      chk($sformatf("v%0d_valid", i), valid0[0], vecs[i].valid);
      chk($sformatf("v%0d_overrun", i), ovr0[0], vecs[i].ovr);
      chk($sformatf("v%0d_ack", i), ack0[0], ACK_EN ? vecs[i].ack : 1'b0);
      chk($sformatf("v%0d_ch1_idle", i), {sb0[15:8], pulse0[1], valid0[1], ovr0[1], ack0[1]}, 0);
    end

    // Reset while in HOLD with 0xA5
    en0 = '0; rdy0 = '0; clr0 = '0;
    repeat (2) step();
    en0[0] = 1'b1; bus0[7:0] = 8'hA5;
    repeat (3) step();
    chk("hold_a5_valid", valid0[0], 1);
    chk("hold_a5_bus", sb0[7:0], 8'hA5);
    en0[0] = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_sync_bus", sb0, 0);
    chk("midrst_valid", valid0, 0);
    chk("midrst_pulse", pulse0, 0);
    chk("midrst_ovr", ovr0, 0);
    chk("midrst_ack", ack0, 0);
    step();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("postrst%0d_valid", k), valid0, 0);
      chk($sformatf("postrst%0d_pulse", k), pulse0, 0);
    end

    // dut1, toggle mode: ch1 toggles at j=0 and j=4
    bus1 = 24'h77_00_33;
    for (int j = 0; j < 11; j++) begin
      en1[1] = (j < 4) ? 1'b1 : 1'b0;
      bus1[15:8] = (j < 4) ? 8'h55 : 8'hAA;
      rdy1[1] = (j == 4 || j == 8);
      step();
      chk($sformatf("t%0d_pulse1", j), pulse1[1], (j == 3 || j == 7));
      chk($sformatf("t%0d_valid1", j), valid1[1], (j == 3 || j == 7));
      chk($sformatf("t%0d_others", j), {pulse1[0], pulse1[2], valid1[0], valid1[2], ovr1}, 0);
      if (j == 3) chk("t3_bus", sb1[15:8], 8'h55);
      if (j == 7) chk("t7_bus", sb1[15:8], 8'hAA);
    end
    chk("t_end_ch0_ch2_bus", {sb1[23:16], sb1[7:0]}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
